pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register; successor to the fixed-payload inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W-bit payload (a packed stage-info struct) with a valid/ready handshake, flush and stall.
- Optional 2-entry skid mode registers in_ready, breaking the combinational ready chain across the pipeline.
- Includes a saturating backpressure counter for performance analysis.

---
 rtl/pipe_stage_skid.sv | 101 ++++++++++
 tb/tb_pipe_stage_skid.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush and stall.
// SKID=1 adds a second entry so in_ready comes straight from a flop.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W  = 64,
  parameter int unsigned       SKID    = 0,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CNT_W-1:0]  bp_q, bp_d;
  logic              in_fire, out_fire, bp_inc;

  assign out_valid = m_valid_q & ~stall;
  assign out_data  = m_data_q;
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = (SKID != 0) ? ~s_valid_q
                   : (~m_valid_q | (out_ready & ~stall));
  assign in_fire   = in_valid & in_ready;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign bp_cnt    = bp_q;

  // Saturating: stop once all ones.
  assign bp_inc = m_valid_q & ~out_fire & ~(&bp_q);
  assign bp_d   = bp_q + {{(CNT_W-1){1'b0}}, bp_inc};

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (SKID == 0) begin
      if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
      end
    end else begin
      unique case (1'b1)
        out_fire & s_valid_q: begin
          m_data_d = s_data_q;
          if (in_fire) s_data_d = in_data;
          else         s_valid_d = 1'b0;
        end
        out_fire & ~s_valid_q: begin
          if (in_fire) m_data_d = in_data;
          else         m_valid_d = 1'b0;
        end
        ~out_fire & in_fire & ~m_valid_q: begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end
        ~out_fire & in_fire & m_valid_q: begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
        end
        default: ;
      endcase
    end
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = RST_VAL;
      s_data_d  = RST_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= RST_VAL;
      s_data_q  <= RST_VAL;
      bp_q      <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      bp_q      <= bp_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (plain, skid, skid with
// 2-bit counter) share stimulus and are checked against a FIFO model.
module tb_pipe_stage_skid;

  localparam logic [31:0] RV2 = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, flush, stall, in_valid, out_ready;
  logic [31:0] in_data;

  logic [2:0]  ir, ov;
  logic [31:0] od [3];
  logic [1:0]  oc [3];
  logic [15:0] bc [3];
  logic [1:0]  bc2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .SKID(0), .RST_VAL(32'h0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(oc[0]), .bp_cnt(bc[0]));

  pipe_stage_skid #(.DATA_W(32), .SKID(1), .RST_VAL(32'h0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(oc[1]), .bp_cnt(bc[1]));

  pipe_stage_skid #(.DATA_W(32), .SKID(1), .RST_VAL(RV2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(oc[2]), .bp_cnt(bc2));

  assign bc[2] = {14'b0, bc2};

  // Reference model: a FIFO of capacity 1 or 2 per instance.
  bit          skid [3] = '{1'b0, 1'b1, 1'b1};
  int          bmax [3] = '{65535, 65535, 3};
  logic [31:0] rv   [3] = '{32'h0, 32'h0, RV2};
  logic [31:0] mq   [3][2];
  int          mn   [3];
  logic [31:0] hd   [3];
  int          bp   [3];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ir(input int i);
    if (skid[i]) return mn[i] < 2;
    return (mn[i] == 0) || (out_ready && !stall);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      mn[i] = 0;
      hd[i] = rv[i];
      bp[i] = 0;
    end
  endtask

  task automatic cyc();
    bit inf [3];
    bit outf [3];
    #1;
    for (int i = 0; i < 3; i++) begin
      inf[i]  = in_valid && m_ir(i);
      outf[i] = (mn[i] > 0) && !stall && out_ready;
      chk($sformatf("in_ready[%0d]", i), {31'b0, ir[i]}, {31'b0, m_ir(i)});
      chk($sformatf("out_valid[%0d]", i), {31'b0, ov[i]},
          {31'b0, (mn[i] > 0) && !stall});
      chk($sformatf("out_data[%0d]", i), od[i], hd[i]);
      chk($sformatf("occupancy[%0d]", i), {30'b0, oc[i]}, mn[i]);
      chk($sformatf("bp_cnt[%0d]", i), {16'b0, bc[i]}, bp[i]);
    end
    chk("inv_s_implies_m", {29'b0,
        u0.s_valid_q & ~u0.m_valid_q,
        u1.s_valid_q & ~u1.m_valid_q,
        u2.s_valid_q & ~u2.m_valid_q}, 32'h0);
    @(posedge clk);
    if (rst) m_reset();
    else begin
      for (int i = 0; i < 3; i++) begin
        if (mn[i] > 0 && !outf[i] && bp[i] < bmax[i]) bp[i]++;
        if (flush) begin
          mn[i] = 0;
          hd[i] = rv[i];
        end else begin
          if (outf[i]) begin
            mq[i][0] = mq[i][1];
            mn[i]--;
          end
          if (inf[i]) begin
            mq[i][mn[i]] = in_data;
            mn[i]++;
          end
          if (mn[i] > 0) hd[i] = mq[i][0];
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit f, input bit s,
                       input bit iv, input logic [31:0] d, input bit ordy);
    rst = r; flush = f; stall = s;
    in_valid = iv; in_data = d; out_ready = ordy;
    cyc();
  endtask

  int sat [6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    // Idle after reset
    drive(0, 0, 0, 0, 32'h0, 1);
    chk("reset_in_ready", {29'b0, ir}, 32'h7);
    chk("reset_out_data2", od[2], RV2);
    // Back-to-back stream
    drive(0, 0, 0, 1, 32'hA, 1);
    chk("stream_a", od[0], 32'hA);
    drive(0, 0, 0, 1, 32'hB, 1);
    chk("stream_b", od[0], 32'hB);
    drive(0, 0, 0, 1, 32'hC, 1);
    chk("stream_c", od[0], 32'hC);
    chk("stream_bp0", {16'b0, bc[0]}, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 1);
    // Skid fill and drain
    drive(0, 0, 0, 1, 32'h11, 0);
    drive(0, 0, 0, 1, 32'h22, 0);
    chk("fill_occ1", {30'b0, oc[1]}, 32'd2);
    chk("fill_ready1", {31'b0, ir[1]}, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 1);
    chk("drain_first", od[1], 32'h22);
    chk("drain_ready1", {31'b0, ir[1]}, 32'h1);
    drive(0, 0, 0, 0, 32'h0, 1);
    // Stall holds payload
    drive(0, 1, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 1, 32'h5A, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 32'h0, 1);
    chk("stall_data0", od[0], 32'h5A);
    drive(0, 0, 0, 0, 32'h0, 1);
    // Flush with two held entries and an input
    drive(0, 0, 0, 1, 32'h31, 0);
    drive(0, 0, 0, 1, 32'h32, 0);
    drive(0, 1, 0, 1, 32'h99, 0);
    chk("flush_occ1", {30'b0, oc[1]}, 32'd0);
    chk("flush_data2", od[2], RV2);
    drive(0, 0, 0, 0, 32'h0, 1);
    // Counter saturation on 2-bit instance
    drive(1, 0, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 1, 32'h77, 0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 32'h0, 0);
      chk($sformatf("sat_%0d", k), {16'b0, bc[2]}, sat[k]);
    end
    drive(1, 0, 0, 1, 32'h88, 0);
    chk("rst_bp2", {16'b0, bc[2]}, 32'h0);
    chk("rst_occ2", {30'b0, oc[2]}, 32'h0);
    // Random traffic
    for (int n = 0; n < 600; n++)
      drive($urandom_range(63) == 0, $urandom_range(15) == 0,
            $urandom_range(3) == 0, $urandom_range(3) != 0,
            $urandom, $urandom_range(1) == 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
